// File: rtl/imm_gen_pkg.sv
// Shared RV32I decode definitions: the opcodes that select an immediate
// format and the encoding of the format code reported alongside the immediate.
package imm_gen_pkg;

    localparam int XLEN_SUPPORTED = 32;

    // Major opcodes, instruction[6:0]
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    // Immediate format codes driven on imm_fmt
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator. The format is chosen from the opcode alone and
// the sign-extended immediate is available combinationally in the decode
// cycle; a registered copy feeds the next pipeline stage.
module imm_gen
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    output logic [XLEN-1:0]   imm32,
    output logic [XLEN-1:0]   imm32_q,
    output logic [2:0]        imm_fmt
);

    logic [31:0] i;

    assign i = instruction;

    // Opcode decode and immediate assembly; X/Z opcodes fall through to the
    // default arm, which reports the R/other format with a zero immediate.
    always_comb begin
        imm_fmt = FMT_R;
        imm32   = '0;
        case (i[6:0])
            OP_IMM, LOAD, JALR, SYSTEM: begin
                imm_fmt = FMT_I;
                imm32   = {{20{i[31]}}, i[31:20]};
            end
            STORE: begin
                imm_fmt = FMT_S;
                imm32   = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            BRANCH: begin
                imm_fmt = FMT_B;
                imm32   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                imm_fmt = FMT_U;
                imm32   = {i[31:12], 12'b0};
            end
            JAL: begin
                imm_fmt = FMT_J;
                imm32   = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            default: begin
                imm_fmt = FMT_R;
                imm32   = '0;
            end
        endcase
    end

    // Pipeline register for the immediate, cleared immediately on reset assertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm32_q <= '0;
        end else begin
            imm32_q <= imm32;
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] imm32;
    logic [31:0] imm32_q;
    logic [2:0]  imm_fmt;

    int checks = 0;
    int errors = 0;

    imm_gen #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .imm32       (imm32),
        .imm32_q     (imm32_q),
        .imm_fmt     (imm_fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference format: a plain lookup of the opcode lists
    function automatic logic [2:0] ref_fmt(input logic [6:0] op);
        if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) return 3'd1;
        if (op == 7'h23) return 3'd2;
        if (op == 7'h63) return 3'd3;
        if (op == 7'h37 || op == 7'h17) return 3'd4;
        if (op == 7'h6f) return 3'd5;
        return 3'd0;
    endfunction

    // Reference immediate computed as a signed integer offset from its fields
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        v = 0;
        case (ref_fmt(i[6:0]))
            3'd1: v = (i[31] ? -2048 : 0) + int'(i[30:20]);
            3'd2: v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
            3'd3: v = (i[31] ? -4096 : 0) + (i[7] ? 2048 : 0)
                      + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            3'd4: v = int'(i[31:12]) * 4096;
            3'd5: v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096
                      + (i[20] ? 2048 : 0) + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic apply_comb(input logic [31:0] instr);
        instruction = instr;
        #1;
        check("imm32", imm32, ref_imm(instr));
        check("imm_fmt", {29'b0, imm_fmt}, {29'b0, ref_fmt(instr[6:0])});
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    vec_t vecs[$];
    logic [6:0] ops[12];

    initial begin
        logic [31:0] r;
        logic [31:0] exp_q;

        vecs.push_back('{32'hFFF100E7, 32'hFFFFFFFF, 3'd1});
        vecs.push_back('{32'h47F100E7, 32'h0000047F, 3'd1});
        vecs.push_back('{32'hC7F100E7, 32'hFFFFFC7F, 3'd1});
        vecs.push_back('{32'h6FF100E7, 32'h000006FF, 3'd1});
        vecs.push_back('{32'h2FF100E7, 32'h000002FF, 3'd1});
        vecs.push_back('{32'hDFF100E7, 32'hFFFFFDFF, 3'd1});
        vecs.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 3'd3});
        vecs.push_back('{32'h123450B7, 32'h12345000, 3'd4});
        vecs.push_back('{32'h0080006F, 32'h00000008, 3'd5});
        vecs.push_back('{32'h46000FA3, 32'h0000047F, 3'd2});
        vecs.push_back('{32'h002081B3, 32'h00000000, 3'd0});

        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6f, 7'h33, 7'h0f, 7'h00};

        rst_n       = 1'b0;
        instruction = 32'hFFF100E7;

        // Directed vectors against literal expectations, no clock edge needed
        foreach (vecs[k]) begin
            instruction = vecs[k].instr;
            #1;
            check($sformatf("dir_imm_%0d", k), imm32, vecs[k].imm);
            check($sformatf("dir_fmt_%0d", k), {29'b0, imm_fmt}, {29'b0, vecs[k].fmt});
        end

        // Reset held across edges keeps the register clear
        instruction = 32'hFFF100E7;
        repeat (3) @(posedge clk);
        #1;
        check("q_in_reset", imm32_q, 32'h0);

        // Release between edges; first rising edge loads the current immediate
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("q_before_edge", imm32_q, 32'h0);
        @(posedge clk);
        #1;
        check("q_first_edge", imm32_q, 32'hFFFFFFFF);

        // Randomised decode with registered-copy check each cycle
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r = $urandom;
            if ($urandom_range(0, 9) != 0)
                r[6:0] = ops[$urandom_range(0, 11)];
            apply_comb(r);
            exp_q = ref_imm(r);
            @(posedge clk);
            #1;
            check("q_load", imm32_q, exp_q);
        end

        // Mid-cycle reset clears the register without waiting for a clock edge
        @(negedge clk);
        instruction = 32'hC7F100E7;
        @(posedge clk);
        #1;
        check("q_pre_drop", imm32_q, 32'hFFFFFC7F);
        #2;
        rst_n = 1'b0;
        #1;
        check("q_async_clear", imm32_q, 32'h0);
        @(posedge clk);
        #1;
        check("q_held_clear", imm32_q, 32'h0);
        check("comb_in_reset", imm32, 32'hFFFFFC7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
